// File: rtl/sram_pkg.sv
// Shared widths and types for the SRAM responder slice.
package sram_pkg;
  localparam int ADR_W = 18;
  localparam int DAT_W = 16;
  localparam int LANES = 2;
  typedef logic [LANES-1:0] lane_en_t;
endpackage

// File: rtl/sram_responder_if.sv
// Asynchronous SRAM pin bundle: strobes/address/data from the initiator, split read data back.
// Handshake: no valid/ready pair; the initiator holds a request on the pins for as long as
// the strobes are asserted, and the responder drives DAT_O only on lanes flagged in DAT_OE.
interface sram_responder_if;
  import sram_pkg::*;
  logic             RAMCS;
  logic             RAMWE;
  logic             RAMOE;
  logic             RAMUB;
  logic             RAMLB;
  logic [ADR_W-1:0] ADR;
  logic [DAT_W-1:0] DAT_I;
  logic [DAT_W-1:0] DAT_O;
  lane_en_t         DAT_OE;

  modport master (output RAMCS, RAMWE, RAMOE, RAMUB, RAMLB, ADR, DAT_I,
                  input  DAT_O, DAT_OE);
  modport slave  (input  RAMCS, RAMWE, RAMOE, RAMUB, RAMLB, ADR, DAT_I,
                  output DAT_O, DAT_OE);
endinterface

// File: rtl/sram_resp_mem.sv
// Single-clock word RAM with per-byte write enables and write-first registered read.
module sram_resp_mem
  import sram_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic             clk,
  input  lane_en_t         we,
  input  logic [AW-1:0]    waddr,
  input  logic [DAT_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [DAT_W-1:0] rdata
);
  logic [DAT_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) mem[waddr][l*8 +: 8] <= wdata[l*8 +: 8];
      // Same-address write in the read cycle wins, byte by byte.
      if (re) rdata[l*8 +: 8] <= (we[l] && (waddr == raddr)) ? wdata[l*8 +: 8]
                                                             : mem[raddr][l*8 +: 8];
    end
  end
endmodule

// File: rtl/sram_responder.sv
// On-chip stand-in for the board SRAM: strobe decode, commit-on-WE-rise writes,
// valid-masked reads through an RD_LAT-deep pipeline, access counters and a protocol flag.
module sram_responder
  import sram_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              greset_n,
  sram_responder_if.slave   bus,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              proto_err
);
  localparam int WORDS = 2**MEM_AW;

  logic             s_cs, s_we, s_oe, s_ub, s_lb;
  logic [ADR_W-1:0] s_adr;
  logic [DAT_W-1:0] s_dat;

  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      {s_cs, s_we, s_oe, s_ub, s_lb} <= 5'b11111;
      s_adr <= '0;
      s_dat <= '0;
    end else begin
      {s_cs, s_we, s_oe, s_ub, s_lb} <= {bus.RAMCS, bus.RAMWE, bus.RAMOE, bus.RAMUB, bus.RAMLB};
      s_adr <= bus.ADR;
      s_dat <= bus.DAT_I;
    end
  end

  logic wr_act, rd_act, commit;
  assign wr_act = !s_cs && !s_we;
  assign rd_act = !s_cs && !s_oe && s_we;

  // Last write-active cycle's request, committed once WE is seen high.
  logic             prev_wr;
  logic [ADR_W-1:0] w_adr;
  logic [DAT_W-1:0] w_dat;
  lane_en_t         w_lanes;
  assign commit = prev_wr && s_we;

  logic [WORDS-1:0]  vbits;
  logic [MEM_AW-1:0] w_idx, r_idx;
  assign w_idx = w_adr[MEM_AW-1:0];
  assign r_idx = s_adr[MEM_AW-1:0];

  lane_en_t         mem_we;
  logic [DAT_W-1:0] mem_wdata, mem_rdata;
  logic             look_valid;

  // A first write to an unwritten word also stores the address bytes into the other lane.
  always_comb begin
    mem_wdata  = {w_lanes[1] ? w_dat[15:8] : w_adr[15:8],
                  w_lanes[0] ? w_dat[7:0]  : w_adr[7:0]};
    mem_we     = '0;
    if (commit) mem_we = vbits[w_idx] ? w_lanes : '1;
    look_valid = vbits[r_idx] || (commit && (w_idx == r_idx));
  end

  sram_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_idx),
    .wdata (mem_wdata),
    .re    (rd_act),
    .raddr (r_idx),
    .rdata (mem_rdata)
  );

  // Stage 1 is the RAM output register; later stages carry resolved data.
  logic             p1_vw;
  logic [DAT_W-1:0] p1_adr, r1;
  logic [4:1]       pv;
  lane_en_t         pl [1:4];
  logic [DAT_W-1:0] pd [2:4];
  assign r1 = p1_vw ? mem_rdata : p1_adr;

  logic             prev_rd;
  logic [ADR_W-1:0] last_adr;
  logic             rd_inc;
  assign rd_inc = rd_act && (!prev_rd || (s_adr != last_adr));

  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      prev_wr   <= 1'b0;
      w_adr     <= '0;
      w_dat     <= '0;
      w_lanes   <= '0;
      vbits     <= '0;
      p1_vw     <= 1'b0;
      p1_adr    <= '0;
      pv        <= '0;
      for (int i = 1; i <= 4; i++) pl[i] <= '0;
      for (int i = 2; i <= 4; i++) pd[i] <= '0;
      prev_rd   <= 1'b0;
      last_adr  <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      prev_wr <= wr_act;
      if (wr_act) begin
        w_adr   <= s_adr;
        w_dat   <= s_dat;
        w_lanes <= {!s_ub, !s_lb};
      end
      if (commit) vbits[w_idx] <= 1'b1;
      if (rd_act) begin
        p1_vw  <= look_valid;
        p1_adr <= s_adr[DAT_W-1:0];
      end
      pv[1] <= rd_act;
      pl[1] <= {!s_ub, !s_lb};
      for (int i = 2; i <= 4; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
      if (pv[1]) pd[2] <= r1;
      if (pv[2]) pd[3] <= pd[2];
      if (pv[3]) pd[4] <= pd[3];
      prev_rd  <= rd_act;
      last_adr <= s_adr;
      if (rd_inc && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
      if (commit && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      if (wr_act && prev_wr && (s_adr != w_adr)) proto_err <= 1'b1;
    end
  end

  logic [DAT_W-1:0] tail_d;
  logic             tail_v;
  lane_en_t         tail_l;

  always_comb begin
    tail_d = pd[4];
    tail_v = pv[4];
    tail_l = pl[4];
    case (RD_LAT)
      1: begin tail_d = r1;    tail_v = pv[1]; tail_l = pl[1]; end
      2: begin tail_d = pd[2]; tail_v = pv[2]; tail_l = pl[2]; end
      3: begin tail_d = pd[3]; tail_v = pv[3]; tail_l = pl[3]; end
      default: ;
    endcase
  end

  // Enables drop as soon as the request leaves S, independent of pipeline depth.
  assign bus.DAT_O  = tail_d;
  assign bus.DAT_OE = (tail_v && rd_act) ? tail_l : '0;
endmodule
